// File: rtl/sump_pkg.sv
// Shared types and constants for the SUMP command sender.
// Flow control: define SUMP_CMD_SENDER_FLOWCTL_EN to honour the pause input.
package sump_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int OP_LONG_BIT = 7;
  localparam int SHORT_BYTES = 1;
  localparam int LONG_BYTES  = 5;
  localparam int FRAME_BITS  = 10;

  localparam int OPCODE_LSB  = 0;
  localparam int OPDATA_LSB  = 8;

  // Bytes still to send after the opcode byte.
  function automatic logic [2:0] extra_bytes(input logic [39:0] c);
    return c[OPCODE_LSB + OP_LONG_BIT] ? 3'(LONG_BYTES - 1) : 3'(SHORT_BYTES - 1);
  endfunction

endpackage

// File: rtl/sump_baud_tick.sv
// Bit-period timer: down-counts DIV cycles and pulses tick on the last one.
// A synchronous restart reloads the count so the next bit gets a full period.
module sump_baud_tick
  import sump_pkg::*;
#(
  parameter int unsigned DIV = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  if (DIV < 2) begin : g_bad_div
    $error("sump_baud_tick: DIV must be >= 2");
  end

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  // Reload on restart or at terminal count, otherwise count down.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (restart || tick) begin
      cnt_d = RELOAD;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sump_cmd_sender.sv
// SUMP command sender: serialises one 40-bit command as 1 or 5 8N1 bytes.
// Optional flow control via macro SUMP_CMD_SENDER_FLOWCTL_EN (pause honoured
// at byte boundaries); without it pause is ignored.
//
// state | meaning
// IDLE  | waiting for a command, tx high
// START | start bit (tx low)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (tx high)
// GAP   | between bytes; only dwelt in while paused
module sump_cmd_sender
  import sump_pkg::*;
#(
  parameter int unsigned FREQ = 100000000,
  parameter int unsigned RATE = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [39:0] cmd,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        pause,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DIV = FREQ / RATE;

  state_t      state_q, state_d;
  logic [39:0] shadow_q, shadow_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  bytes_left_q, bytes_left_d;
  logic        done_q, done_d;
  logic        tick;
  logic        restart;
  logic        accept;
  logic        hold;

`ifdef SUMP_CMD_SENDER_FLOWCTL_EN
  assign hold = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE) && !hold;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  sump_baud_tick #(.DIV(DIV)) u_baud (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state, byte/bit sequencing and tx level.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    bit_idx_d    = bit_idx_q;
    bytes_left_d = bytes_left_q;
    done_d       = 1'b0;
    restart      = 1'b0;
    tx           = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shadow_d     = cmd;
          bytes_left_d = extra_bytes(cmd);
          bit_idx_d    = 3'd0;
          restart      = 1'b1;
          state_d      = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (tick) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx = shadow_q[bit_idx_q];
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bytes_left_q != 3'd0) begin
            bytes_left_d = bytes_left_q - 3'd1;
            shadow_d     = {8'h00, shadow_q[39:8]};
            // GAP is only occupied while held; otherwise go straight on.
            state_d      = hold ? GAP : START;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (!hold) begin
          restart = 1'b1;
          state_d = START;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      bit_idx_q    <= 3'd0;
      bytes_left_q <= 3'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      bit_idx_q    <= bit_idx_d;
      bytes_left_q <= bytes_left_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_sump_cmd_sender.sv
// Directed bench for sump_cmd_sender with DIV=10.
module tb_sump_cmd_sender;

  localparam int unsigned FREQ = 100000000;
  localparam int unsigned RATE = 10000000;
  localparam int DIV  = 10;
  localparam int BYTE_CYC = 10 * DIV;
  localparam int NCAP = 700;

`ifdef SUMP_CMD_SENDER_FLOWCTL_EN
  localparam int PAUSE_GAP = 25;
`else
  localparam int PAUSE_GAP = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [39:0] cmd = '0;
  logic        cmd_valid = 1'b0;
  logic        pause = 1'b0;
  logic        cmd_ready, tx, busy, done;

  int checks = 0;
  int errors = 0;

  logic tx_s   [NCAP];
  logic busy_s [NCAP];
  logic done_s [NCAP];
  logic rdy_s  [NCAP];
  logic exp_tx [NCAP];

  sump_cmd_sender #(.FREQ(FREQ), .RATE(RATE)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .pause     (pause),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Present a command; returns at the negedge of the first tx-low cycle.
  task automatic issue(input logic [39:0] c);
    @(negedge clock);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clock);
  endtask

  // Record outputs for n cycles, optionally queuing a follow-on command
  // and driving pause for samples [p_on, p_off).
  task automatic capture(input int n, input logic [39:0] next_cmd, input logic keep_valid,
                         input int p_on, input int p_off);
    for (int i = 0; i < n; i++) begin
      tx_s[i] = tx; busy_s[i] = busy; done_s[i] = done; rdy_s[i] = cmd_ready;
      if (i == 0) begin
        cmd = next_cmd;
        cmd_valid = keep_valid;
      end else if (done_s[i-1]) begin
        cmd_valid = 1'b0;
      end
      pause = (i >= p_on) && (i < p_off);
      @(negedge clock);
    end
    pause = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NCAP; i++) exp_tx[i] = 1'b1;
  endtask

  // Lay out nb frames of 'bytes' (LSB byte first) starting at 'start'.
  task automatic put_frames(input int start, input logic [39:0] bytes, input int nb,
                            input int gap_after, input int gap_len);
    logic [7:0] b;
    int base;
    for (int j = 0; j < nb; j++) begin
      b = bytes[8*j +: 8];
      base = start + j * BYTE_CYC + ((j > gap_after) ? gap_len : 0);
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < DIV; c++) begin
          exp_tx[base + k*DIV + c] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        end
      end
    end
  endtask

  function automatic logic [7:0] decode_at(input int base);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) d[k] = tx_s[base + DIV*(k+1) + DIV/2];
    return d;
  endfunction

  function automatic int first_done(input int from, input int n);
    for (int i = from; i < n; i++) if (done_s[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    cmd = 40'h00_0000_0001;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0", tx, busy, done);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", cmd_ready);
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: tx=%b busy=%b ready=%b, required 1 0 1", tx, busy, cmd_ready);
    end
  endtask

  task automatic test_short();
    int bad, nb;
    issue(40'h00_0000_0001);
    capture(110, 40'h0, 1'b0, -1, -1);
    clear_exp();
    put_frames(0, 40'h00_0000_0001, 1, 9, 0);
    bad = 0;
    for (int i = 0; i < 110; i++) if (tx_s[i] !== exp_tx[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL short_waveform: %0d mismatching cycles, required 0", bad);
    end
    checks++;
    if (decode_at(0) !== 8'h01) begin
      errors++;
      $display("FAIL short_byte: got %h, required 01", decode_at(0));
    end
    checks++;
    if (first_done(0, 110) != 100) begin
      errors++;
      $display("FAIL short_done_time: got %0d, required 100", first_done(0, 110));
    end
    nb = 0;
    for (int i = 0; i < 100; i++) if (busy_s[i] !== 1'b1 || rdy_s[i] !== 1'b0) nb++;
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL short_busy: %0d cycles not busy, required 0", nb);
    end
    checks++;
    if (busy_s[100] !== 1'b0 || rdy_s[100] !== 1'b1 || done_s[101] !== 1'b0) begin
      errors++;
      $display("FAIL short_end: busy=%b ready=%b next_done=%b, required 0 1 0",
               busy_s[100], rdy_s[100], done_s[101]);
    end
  endtask

  task automatic run_long(input string tag, input int p_on, input int p_off, input int gap);
    logic [7:0] exp_b [5];
    logic [39:0] rx;
    int bad, base;
    exp_b[0] = 8'hC0; exp_b[1] = 8'h78; exp_b[2] = 8'h56; exp_b[3] = 8'h34; exp_b[4] = 8'h12;
    issue(40'h12_3456_78C0);
    capture(540, 40'h0, 1'b0, p_on, p_off);
    clear_exp();
    put_frames(0, 40'h12_3456_78C0, 5, 1, gap);
    bad = 0;
    for (int i = 0; i < 540; i++) if (tx_s[i] !== exp_tx[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_waveform: %0d mismatching cycles, required 0", tag, bad);
    end
    rx = '0;
    for (int j = 0; j < 5; j++) begin
      base = j * BYTE_CYC + ((j > 1) ? gap : 0);
      rx[8*j +: 8] = decode_at(base);
      checks++;
      if (decode_at(base) !== exp_b[j]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h, required %h", tag, j, decode_at(base), exp_b[j]);
      end
    end
    checks++;
    if (rx !== 40'h12_3456_78C0) begin
      errors++;
      $display("FAIL %s_loopback: got %h, required 12345678c0", tag, rx);
    end
    checks++;
    if (first_done(0, 540) != 500 + gap) begin
      errors++;
      $display("FAIL %s_done_time: got %0d, required %0d", tag, first_done(0, 540), 500 + gap);
    end
    bad = 0;
    for (int i = 0; i < 500 + gap; i++) if (busy_s[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_busy: %0d cycles not busy, required 0", tag, bad);
    end
  endtask

  task automatic test_long();
    run_long("long", -1, -1, 0);
  endtask

  task automatic test_pause();
    run_long("pause", 150, 224, PAUSE_GAP);
  endtask

  task automatic test_back_to_back();
    int bad;
    issue(40'h00_0000_0011);
    capture(610, 40'h00_0000_3C82, 1'b1, -1, -1);
    clear_exp();
    put_frames(0, 40'h00_0000_0011, 1, 9, 0);
    put_frames(101, 40'h00_0000_3C82, 5, 9, 0);
    bad = 0;
    for (int i = 0; i < 610; i++) if (tx_s[i] !== exp_tx[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_waveform: %0d mismatching cycles, required 0", bad);
    end
    checks++;
    if (decode_at(0) !== 8'h11) begin
      errors++;
      $display("FAIL b2b_first_byte: got %h, required 11", decode_at(0));
    end
    checks++;
    if (first_done(0, 610) != 100 || tx_s[100] !== 1'b1 || tx_s[101] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: done=%0d tx100=%b tx101=%b, required 100 1 0",
               first_done(0, 610), tx_s[100], tx_s[101]);
    end
    bad = 0;
    for (int i = 1; i < 100; i++) if (rdy_s[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_ready_busy: ready high %0d cycles while busy, required 0", bad);
    end
    checks++;
    if (decode_at(101 + BYTE_CYC) !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_second_data: got %h, required 3c", decode_at(101 + BYTE_CYC));
    end
    checks++;
    if (first_done(101, 610) != 601) begin
      errors++;
      $display("FAIL b2b_second_done: got %0d, required 601", first_done(101, 610));
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    issue(40'h12_3456_78C0);
    cmd_valid = 1'b0;
    repeat (37) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before: got %b, required 1", busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_now: tx=%b busy=%b ready=%b done=%b, required 1 0 1 0",
               tx, busy, cmd_ready, done);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || tx !== 1'b1) bad++;
    end
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_no_done: %0d bad cycles after reset, required 0", bad);
    end
    issue(40'h00_0000_005A);
    capture(110, 40'h0, 1'b0, -1, -1);
    clear_exp();
    put_frames(0, 40'h00_0000_005A, 1, 9, 0);
    bad = 0;
    for (int i = 0; i < 110; i++) if (tx_s[i] !== exp_tx[i]) bad++;
    checks++;
    if (bad != 0 || decode_at(0) !== 8'h5A) begin
      errors++;
      $display("FAIL mid_next_cmd: %0d mismatching cycles, byte %h, required 0 and 5a", bad, decode_at(0));
    end
    checks++;
    if (first_done(0, 110) != 100) begin
      errors++;
      $display("FAIL mid_next_done: got %0d, required 100", first_done(0, 110));
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_mid();
    test_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
